menu_rom_arbiter: RTL and testbench
===================================

MENU_ROM_ARBITER -- requirements
Module: menu_rom_arbiter

Interface
REQ-001 Parameter: BURST_MAX, default 4, maximum consecutive grants to one requester while others are waiting (legal range 1..15).
REQ-002 Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset; synchronous, active-high.
REQ-003 Ports:
- req  input  3  per-requester read request level; bit i belongs to requester i.
- addr0, addr1, addr2  input  8 each  char_xy address of requester 0/1/2; must be valid while the matching req bit is high.
REQ-004 Ports:
- gnt  output  3  one-hot grant, combinational, zero or one bit set.
- rom_addr  output  8  registered char_xy driven to the menu text ROM.
REQ-005 Ports:
- rom_data  input  7  char_code from the ROM; valid one clock after rom_addr changes.
REQ-006 Ports:
- rsp_valid  output  3  one-hot registered response strobe identifying the requester.
- rsp_data  output  7  combinational pass-through of rom_data.

Function
REQ-007 The block SHALL share one ROM read port among 3 requesters using round-robin arbitration with burst retention.
REQ-008 gnt SHALL be computed from req, the priority pointer, the current owner and the burst count; gnt SHALL be 0 when req == 0 or rst == 1.
REQ-009 A transfer SHALL occur on any rising edge where req[i] & gnt[i]; a requester wanting a single read SHALL drop req after that edge.
REQ-010 On a transfer edge, rom_addr SHALL load addr<i> of the granted requester, and stage-1 id SHALL load gnt.
- With no transfer, rom_addr SHALL hold and stage-1 id SHALL load 0.
REQ-011 On every edge, rsp_valid SHALL load stage-1 id.
- Read latency SHALL be exactly 2 edges: the response for the transfer at edge k appears after edge k+1, aligned with rom_data.
REQ-012 Throughput SHALL be one transfer per cycle; back-to-back transfers to the same or different requesters SHALL be allowed.
REQ-013 Ownership SHALL use two states, IDLE (no owner) and OWNED (owner id, burst count 1..BURST_MAX):
- IDLE -> OWNED on a transfer; count = 1.
- OWNED, owner req high and count < BURST_MAX: the owner SHALL retain gnt; count increments per transfer.
- OWNED, owner req high, count == BURST_MAX, another req pending: grant SHALL rotate to the next requester in round-robin order; count = 1.
- OWNED, count == BURST_MAX, no other req pending: the owner SHALL be regranted; count restarts at 1.
- Owner req low: select by round-robin among the pending requesters; return to IDLE if none are pending.
REQ-014 Round-robin order: the search SHALL start at (last_winner+1) mod 3 and continue 0->1->2->0; last_winner SHALL update on each rotation or new selection.
REQ-015 The burst count width SHALL be 4 bits; the count SHALL never exceed BURST_MAX and SHALL never wrap.
REQ-016 A requester dropping req mid-burst SHALL lose ownership in that same cycle; no grant SHALL be issued to a requester whose req is low.

Reset
REQ-017 While rst is high on an edge, the block SHALL set:
- state = IDLE, count = 0, last_winner = 2 (requester 0 highest priority next);
- rom_addr = 8'h00, stage-1 id = 0, rsp_valid = 3'b000.
REQ-018 Reset asserted mid-burst or with reads in flight SHALL discard them; no rsp_valid SHALL be asserted on the edge after reset is released unless a new transfer occurs.

Verification
REQ-019 The bench SHALL cover these scenarios:
- Single read: after reset, req=3'b001, addr0=8'h40 for one cycle -> gnt=3'b001 that cycle; two edges later rsp_valid=3'b001, rsp_data=7'h35.
- Simultaneous requests: req=3'b111 held, BURST_MAX=1, addr0=8'h40, addr1=8'h91, addr2=8'hC0 -> grant order 0,1,2,0...; responses 7'h35, 7'h01, 7'h30 in that order, one per cycle.
- Burst cap: BURST_MAX=4, req=3'b011 held -> gnt 0 for 4 cycles, then 1 for 4 cycles, repeating; no bubbles.
- Lone requester: req=3'b100 held for 10 cycles -> gnt=3'b100 every cycle; 10 consecutive rsp_valid=3'b100.
- Mid-burst drop: requester 0 owns with count 2, req0 falls while req2 is high -> gnt=3'b100 in the same cycle.
- Reset mid-operation: rst pulsed while 2 reads are in flight -> rsp_valid=0 and rom_addr=8'h00 after the edge; the next req=3'b010 is granted normally.

Source files
------------

// File: rtl/menu_rom_arbiter.sv
// Round-robin arbiter with burst retention sharing one menu text ROM read port
// among three requesters; two-edge read latency with a registered response strobe.
module menu_rom_arbiter #(
  parameter int BURST_MAX = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic [7:0] addr0,
  input  logic [7:0] addr1,
  input  logic [7:0] addr2,
  output logic [2:0] gnt,
  output logic [7:0] rom_addr,
  input  logic [6:0] rom_data,
  output logic [2:0] rsp_valid,
  output logic [6:0] rsp_data
);

  localparam logic [3:0] BMAX = 4'(BURST_MAX);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t     state, state_nxt;
  logic [1:0] owner, owner_nxt;
  logic [1:0] last, last_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [2:0] s1_id;
  logic [2:0] own_oh;
  logic [1:0] gidx;

  // Search starts just after the last winner; lower k has higher priority,
  // so it is evaluated last and overrides.
  function automatic logic [2:0] rr_pick(input logic [2:0] r, input logic [1:0] lw);
    logic [2:0] g;
    logic [1:0] idx;
    g = '0;
    for (int k = 2; k >= 0; k--) begin
      idx = 2'((int'(lw) + 1 + k) % 3);
      if (r[idx]) g = 3'b001 << idx;
    end
    return g;
  endfunction

  always_comb begin
    gnt       = '0;
    state_nxt = state;
    owner_nxt = owner;
    cnt_nxt   = cnt;
    last_nxt  = last;
    own_oh    = 3'b001 << owner;
    if (!rst && req != 3'b000) begin
      if (state == OWNED && (req & own_oh) != 3'b000) begin
        if (cnt < BMAX)                        gnt = own_oh;
        else if ((req & ~own_oh) != 3'b000)    gnt = rr_pick(req & ~own_oh, last);
        else                                   gnt = own_oh;
      end else begin
        gnt = rr_pick(req, last);
      end
    end
    gidx = gnt[1] ? 2'd1 : (gnt[2] ? 2'd2 : 2'd0);
    if (gnt != 3'b000) begin
      if (state == OWNED && gidx == owner) begin
        // Regrant at the cap restarts the burst rather than wrapping.
        cnt_nxt = (cnt >= BMAX) ? 4'd1 : 4'(cnt + 4'd1);
      end else begin
        state_nxt = OWNED;
        owner_nxt = gidx;
        cnt_nxt   = 4'd1;
        last_nxt  = gidx;
      end
    end else begin
      state_nxt = IDLE;
      cnt_nxt   = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= 2'd0;
      cnt       <= 4'd0;
      last      <= 2'd2;
      rom_addr  <= 8'h00;
      s1_id     <= 3'b000;
      rsp_valid <= 3'b000;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      cnt       <= cnt_nxt;
      last      <= last_nxt;
      s1_id     <= gnt;
      rsp_valid <= s1_id;
      if (gnt != 3'b000)
        rom_addr <= gnt[0] ? addr0 : (gnt[1] ? addr1 : addr2);
    end
  end

  assign rsp_data = rom_data;

endmodule

// File: tb/tb_menu_rom_arbiter.sv
// Bench for menu_rom_arbiter: two instances (BURST_MAX 4 and 1) share stimulus,
// checked against directed constants and an integer-level reference model.
module tb_menu_rom_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] req;
  logic [7:0] a0, a1, a2;
  logic [2:0] g4, g1, rv4, rv1;
  logic [7:0] ra4, ra1;
  logic [6:0] rq4, rq1, rd4, rd1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  menu_rom_arbiter #(.BURST_MAX(4)) dut4 (
    .clk(clk), .rst(rst), .req(req), .addr0(a0), .addr1(a1), .addr2(a2),
    .gnt(g4), .rom_addr(ra4), .rom_data(rq4), .rsp_valid(rv4), .rsp_data(rd4));

  menu_rom_arbiter #(.BURST_MAX(1)) dut1 (
    .clk(clk), .rst(rst), .req(req), .addr0(a0), .addr1(a1), .addr2(a2),
    .gnt(g1), .rom_addr(ra1), .rom_data(rq1), .rsp_valid(rv1), .rsp_data(rd1));

  function automatic logic [6:0] rom_f(input logic [7:0] a);
    case (a)
      8'h40:   return 7'h35;
      8'h91:   return 7'h01;
      8'hC0:   return 7'h30;
      default: return 7'(a ^ 8'h2B);
    endcase
  endfunction

  // Synchronous-read ROM: data valid one clock after the address.
  always @(posedge clk) begin
    rq4 <= rom_f(ra4);
    rq1 <= rom_f(ra1);
  end

  // Reference model: ownership as integers, -1 meaning no owner.
  int         bm    [2] = '{4, 1};
  int         m_own [2];
  int         m_cnt [2];
  int         m_lw  [2];
  logic [7:0] m_ra  [2];
  logic [2:0] m_s1  [2];
  logic [2:0] m_rv  [2];
  logic [6:0] m_rd  [2];

  function automatic logic [7:0] aof(input int i);
    return (i == 0) ? a0 : ((i == 1) ? a1 : a2);
  endfunction

  function automatic logic [2:0] oh(input int i);
    return (i < 0) ? 3'b000 : 3'(1 << i);
  endfunction

  function automatic int pick(input logic [2:0] r, input int lw);
    for (int k = 1; k <= 3; k++) begin
      int i;
      i = (lw + k) % 3;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  function automatic int mgnt(input int d);
    logic [2:0] others;
    if (rst || req == 3'b000) return -1;
    if (m_own[d] >= 0 && req[m_own[d]]) begin
      if (m_cnt[d] < bm[d]) return m_own[d];
      others = req & ~oh(m_own[d]);
      return (others != 3'b000) ? pick(others, m_lw[d]) : m_own[d];
    end
    return pick(req, m_lw[d]);
  endfunction

  task automatic model_update();
    for (int d = 0; d < 2; d++) begin
      int g;
      g = mgnt(d);
      m_rd[d] = rom_f(m_ra[d]);
      if (rst) begin
        m_own[d] = -1; m_cnt[d] = 0; m_lw[d] = 2;
        m_ra[d] = 8'h00; m_s1[d] = 3'b000; m_rv[d] = 3'b000;
      end else begin
        m_rv[d] = m_s1[d];
        m_s1[d] = oh(g);
        if (g >= 0) begin
          m_ra[d] = aof(g);
          if (g == m_own[d]) m_cnt[d] = (m_cnt[d] == bm[d]) ? 1 : m_cnt[d] + 1;
          else begin m_own[d] = g; m_cnt[d] = 1; m_lw[d] = g; end
        end else begin
          m_own[d] = -1; m_cnt[d] = 0;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 3'b000;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 3'b111; a0 = 8'h11; a1 = 8'h22; a2 = 8'h33;
    #1;
    tests++; if (g4 !== 3'b000) begin fails++; $display("FAIL reset_gnt got %b want 000", g4); end
    step();
    tests++; if (rv4 !== 3'b000 || rv1 !== 3'b000) begin fails++; $display("FAIL reset_rsp got %b/%b want 000", rv4, rv1); end
    tests++; if (ra4 !== 8'h00) begin fails++; $display("FAIL reset_addr got %h want 00", ra4); end
    rst = 1'b0; req = 3'b000;
    step();
    tests++; if (rv4 !== 3'b000) begin fails++; $display("FAIL reset_norsp got %b want 000", rv4); end
  endtask

  task automatic test_single_read();
    do_reset();
    req = 3'b001; a0 = 8'h40;
    #1;
    tests++; if (g4 !== 3'b001) begin fails++; $display("FAIL single_gnt got %b want 001", g4); end
    step();
    req = 3'b000;
    step();
    tests++; if (rv4 !== 3'b001) begin fails++; $display("FAIL single_rsp got %b want 001", rv4); end
    tests++; if (rd4 !== 7'h35) begin fails++; $display("FAIL single_data got %h want 35", rd4); end
    step();
    tests++; if (rv4 !== 3'b000) begin fails++; $display("FAIL single_once got %b want 000", rv4); end
  endtask

  task automatic test_simultaneous();
    logic [6:0] exp_d [3] = '{7'h35, 7'h01, 7'h30};
    do_reset();
    req = 3'b111; a0 = 8'h40; a1 = 8'h91; a2 = 8'hC0;
    for (int i = 0; i < 7; i++) begin
      #1;
      tests++; if (g1 !== oh(i % 3)) begin fails++; $display("FAIL simul_gnt[%0d] got %b want %b", i, g1, oh(i % 3)); end
      step();
      if (i >= 1) begin
        tests++;
        if (rv1 !== oh((i - 1) % 3) || rd1 !== exp_d[(i - 1) % 3]) begin
          fails++; $display("FAIL simul_rsp[%0d] got %b/%h want %b/%h", i, rv1, rd1, oh((i - 1) % 3), exp_d[(i - 1) % 3]);
        end
      end
    end
    req = 3'b000;
  endtask

  task automatic test_burst_cap();
    do_reset();
    req = 3'b011; a0 = 8'h05; a1 = 8'h06;
    for (int i = 0; i < 16; i++) begin
      #1;
      tests++;
      if (g4 !== (((i / 4) % 2 == 0) ? 3'b001 : 3'b010)) begin
        fails++; $display("FAIL burst_gnt[%0d] got %b", i, g4);
      end
      step();
    end
    req = 3'b000;
  endtask

  task automatic test_lone();
    do_reset();
    req = 3'b100; a2 = 8'h77;
    for (int i = 0; i < 11; i++) begin
      if (i == 10) req = 3'b000;
      #1;
      if (i < 10) begin
        tests++; if (g4 !== 3'b100 || g1 !== 3'b100) begin fails++; $display("FAIL lone_gnt[%0d] got %b/%b want 100", i, g4, g1); end
      end
      step();
      if (i >= 1) begin
        tests++; if (rv4 !== 3'b100) begin fails++; $display("FAIL lone_rsp[%0d] got %b want 100", i, rv4); end
      end
    end
  endtask

  task automatic test_mid_drop();
    do_reset();
    req = 3'b101; a0 = 8'h12; a2 = 8'h34;
    step(); step();
    req = 3'b100;
    #1;
    tests++; if (g4 !== 3'b100) begin fails++; $display("FAIL drop_gnt got %b want 100", g4); end
    step();
    req = 3'b000;
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 3'b001; a0 = 8'h40;
    step();
    req = 3'b010; a1 = 8'h91;
    step();
    rst = 1'b1;
    #1;
    tests++; if (g4 !== 3'b000) begin fails++; $display("FAIL rmid_gnt got %b want 000", g4); end
    step();
    tests++; if (rv4 !== 3'b000 || ra4 !== 8'h00) begin fails++; $display("FAIL rmid_clr got %b/%h want 000/00", rv4, ra4); end
    rst = 1'b0; req = 3'b000;
    step();
    tests++; if (rv4 !== 3'b000) begin fails++; $display("FAIL rmid_stale got %b want 000", rv4); end
    req = 3'b010; a1 = 8'h91;
    #1;
    tests++; if (g4 !== 3'b010) begin fails++; $display("FAIL rmid_regnt got %b want 010", g4); end
    step();
    req = 3'b000;
    step();
    tests++; if (rv4 !== 3'b010 || rd4 !== 7'h01) begin fails++; $display("FAIL rmid_rsp got %b/%h want 010/01", rv4, rd4); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      for (int b = 0; b < 3; b++)
        if ($urandom_range(0, 3) == 0) req[b] = ~req[b];
      a0 = 8'($urandom); a1 = 8'($urandom); a2 = 8'($urandom);
      rst = ($urandom_range(0, 49) == 0);
      #1;
      tests++;
      if (g4 !== oh(mgnt(0)) || g1 !== oh(mgnt(1))) begin
        fails++; $display("FAIL rand_gnt[%0d] got %b/%b want %b/%b", i, g4, g1, oh(mgnt(0)), oh(mgnt(1)));
      end
      step();
      tests++;
      if (rv4 !== m_rv[0] || rv1 !== m_rv[1] || ra4 !== m_ra[0] || ra1 !== m_ra[1]) begin
        fails++; $display("FAIL rand_pipe[%0d] got %b/%b %h/%h want %b/%b %h/%h",
                          i, rv4, rv1, ra4, ra1, m_rv[0], m_rv[1], m_ra[0], m_ra[1]);
      end
      if (m_rv[0] != 3'b000) begin
        tests++; if (rd4 !== m_rd[0]) begin fails++; $display("FAIL rand_data4[%0d] got %h want %h", i, rd4, m_rd[0]); end
      end
      if (m_rv[1] != 3'b000) begin
        tests++; if (rd1 !== m_rd[1]) begin fails++; $display("FAIL rand_data1[%0d] got %h want %h", i, rd1, m_rd[1]); end
      end
    end
    rst = 1'b0; req = 3'b000;
  endtask

  initial begin
    rst = 1'b1; req = 3'b000; a0 = '0; a1 = '0; a2 = '0;
    for (int d = 0; d < 2; d++) begin
      m_own[d] = -1; m_cnt[d] = 0; m_lw[d] = 2;
      m_ra[d] = '0; m_s1[d] = '0; m_rv[d] = '0; m_rd[d] = '0;
    end
    #1;
    test_reset();
    test_single_read();
    test_simultaneous();
    test_burst_cap();
    test_lone();
    test_mid_drop();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
